// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive paths
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;
  localparam int DEFAULT_DATA_BITS    = 8;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tx_baud_counter.sv
// rtl/tx_baud_counter.sv - full-bit baud down-counter; tick while running at count 0
module tx_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic tx_rst,
  input  logic load,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (tx_rst) begin
      cnt_q <= RELOAD;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (run) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, LSB first, one stop bit
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 tx_rst,
  input  logic                 tx_en,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 out_d, busy_d, done_d;
  logic                 baud_load, baud_run, baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  tx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .tx_rst(tx_rst),
    .load  (baud_load),
    .run   (baud_run),
    .tick  (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    baud_load = 1'b0;
    baud_run  = (state_q != IDLE);
    out_d     = LINE_IDLE;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    if (!tx_en) begin
      state_d   = IDLE;
      idx_d     = '0;
      baud_load = 1'b1;
      baud_run  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_start) begin
            state_d   = START;
            sr_d      = tx_data;
            idx_d     = '0;
            baud_load = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_d     = ^tx_data;
`endif
          end
        end
        START: begin
          if (baud_tick) begin
            state_d   = DATA;
            baud_load = 1'b1;
          end
        end
        DATA: begin
          if (baud_tick) begin
            baud_load = 1'b1;
            sr_d      = sr_q >> 1;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            state_d   = STOP;
            baud_load = 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            state_d   = IDLE;
            baud_load = 1'b1;
            done_d    = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          baud_load = 1'b1;
        end
      endcase
    end

    // Line level is decoded from the next state so tx_out can be a plain flop.
    case (state_d)
      START:   out_d = START_LEVEL;
      DATA:    out_d = sr_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  out_d = par_d;
`endif
      STOP:    out_d = STOP_LEVEL;
      default: out_d = LINE_IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (tx_rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      tx_out  <= LINE_IDLE;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      tx_out  <= out_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - table-driven bench for uart_tx (CLKS_PER_BIT=4, DATA_BITS=8)
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * C;

  logic       clk;
  logic       tx_rst;
  logic       tx_en;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (8)
  ) dut (
    .clk     (clk),
    .tx_rst  (tx_rst),
    .tx_en   (tx_en),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_out  (tx_out),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line image: {start, d0..d7, even parity, stop}, first bit sent at [10].
  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;
    bit          chain_next;
    int          mid_j;
    logic [7:0]  mid_data;
  } vec_t;

  task automatic check(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic line_bit(input logic [10:0] e, input int s);
`ifdef UART_TX_PARITY_EN
    return e[10-s];
`else
    return (s >= 9) ? e[0] : e[10-s];
`endif
  endfunction

  // Called at a negedge with tx_start already raised; returns at the negedge of the done cycle.
  task automatic frame_check(input logic [10:0] exp, input string nm,
                             input int mid_j, input logic [7:0] mid_data);
    for (int j = 1; j <= FRAME_CYC; j++) begin
      int s;
      @(negedge clk);
      s = (j - 1) / C;
      check($sformatf("%s out j=%0d", nm, j), tx_out, line_bit(exp, s));
      if ((j - 1) % C == 0) begin
        check($sformatf("%s busy slot %0d", nm, s), tx_busy, 1'b1);
        check($sformatf("%s done slot %0d", nm, s), tx_done, 1'b0);
      end
      if (j == 1) begin
        tx_start = 1'b0;
        tx_data  = ~tx_data;
      end
      if (j == mid_j) begin
        tx_start = 1'b1;
        tx_data  = mid_data;
      end else if (j == mid_j + 1) begin
        tx_start = 1'b0;
      end
    end
    @(negedge clk);
    check({nm, " end done"}, tx_done, 1'b1);
    check({nm, " end busy"}, tx_busy, 1'b0);
    check({nm, " end out"},  tx_out,  1'b1);
  endtask

  task automatic idle_check(input string nm, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check($sformatf("%s out %0d", nm, k),  tx_out,  1'b1);
      check($sformatf("%s busy %0d", nm, k), tx_busy, 1'b0);
      check($sformatf("%s done %0d", nm, k), tx_done, 1'b0);
    end
  endtask

  vec_t vecs[6];
  bit   chained;

  initial begin
    vecs[0] = '{8'hA5, 11'b0_10100101_0_1, 1'b0, -1, 8'h00};
    vecs[1] = '{8'h00, 11'b0_00000000_0_1, 1'b1, -1, 8'h00};
    vecs[2] = '{8'hFF, 11'b0_11111111_0_1, 1'b0, -1, 8'h00};
    vecs[3] = '{8'h81, 11'b0_10000001_0_1, 1'b0, 15, 8'h3C};
    vecs[4] = '{8'h07, 11'b0_11100000_1_1, 1'b0, -1, 8'h00};
    vecs[5] = '{8'h3C, 11'b0_00111100_0_1, 1'b0, -1, 8'h00};

    tx_rst   = 1'b1;
    tx_en    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // Reset held three cycles, with a start request that must be ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tx_start = (k == 1);
      if (k > 0) begin
        check($sformatf("reset out %0d", k),  tx_out,  1'b1);
        check($sformatf("reset busy %0d", k), tx_busy, 1'b0);
        check($sformatf("reset done %0d", k), tx_done, 1'b0);
      end
    end
    tx_start = 1'b0;
    tx_rst   = 1'b0;
    idle_check("idle", 50);

    chained = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!chained) @(negedge clk);
      tx_data  = vecs[i].data;
      tx_start = 1'b1;
      frame_check(vecs[i].line, $sformatf("vec%0d", i), vecs[i].mid_j, vecs[i].mid_data);
      chained = vecs[i].chain_next;
      if (!chained) begin
        tx_start = 1'b0;
        idle_check($sformatf("gap%0d", i), (vecs[i].mid_j > 0) ? 2 * FRAME_CYC : 4);
      end
    end

    // Abort with tx_en low during data bit 3 of an all-zero frame.
    @(negedge clk);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if (j == 1) tx_start = 1'b0;
    end
    check("abort pre out",  tx_out,  1'b0);
    check("abort pre busy", tx_busy, 1'b1);
    tx_en    = 1'b0;
    tx_start = 1'b1;
    idle_check("abort en", 8);
    tx_start = 1'b0;
    tx_en    = 1'b1;
    idle_check("abort post", 12);

    // Reset during the start bit, with a start request on the same edges.
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("rst start bit j1", tx_out, 1'b0);
    @(negedge clk);
    check("rst start bit j2", tx_out, 1'b0);
    tx_rst   = 1'b1;
    tx_start = 1'b1;
    @(negedge clk);
    check("rst mid out",  tx_out,  1'b1);
    check("rst mid busy", tx_busy, 1'b0);
    check("rst mid done", tx_done, 1'b0);
    @(negedge clk);
    check("rst+start busy", tx_busy, 1'b0);
    tx_rst   = 1'b0;
    tx_start = 1'b0;
    idle_check("rst post", 12);

    tx_data  = 8'h55;
    tx_start = 1'b1;
    frame_check(11'b0_10101010_0_1, "fresh55", -1, 8'h00);
    tx_start = 1'b0;
    idle_check("final", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
